// File: rtl/led_count_ctrl_if.sv
// Operator-side signals of the LED counter controller: switches and key in,
// counter strobes, load data and FSM state out.
interface led_count_ctrl_if;
    logic       key1_n;
    logic       run_sw;
    logic       dir_sw;
    logic [1:0] rate_sw;
    logic [9:0] sw_val;
    logic       cnt_en;
    logic       cnt_ld;
    logic       cnt_up;
    logic [9:0] ld_data;
    logic [1:0] state;

    modport master (
        output key1_n, run_sw, dir_sw, rate_sw, sw_val,
        input  cnt_en, cnt_ld, cnt_up, ld_data, state
    );

    modport slave (
        input  key1_n, run_sw, dir_sw, rate_sw, sw_val,
        output cnt_en, cnt_ld, cnt_up, ld_data, state
    );
endinterface

// File: rtl/led_count_ctrl.sv
// Run/pause/load controller for the 10-bit LED counter: generates count-enable
// and load strobes in the CLOCK_50 domain from a clock-enable divider and a debounced key.
module led_count_ctrl #(
    parameter int unsigned CLK_DIV   = 5_000_000,
    parameter int unsigned DIV_W     = 32,
    parameter int unsigned DB_CYCLES = 500_000,
    parameter int unsigned DB_W      = 20
) (
    input  logic              CLOCK_50,
    input  logic              KEY0,
    led_count_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        LOAD  = 2'b11
    } state_t;

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_BASE = DIV_W'(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    logic [DB_W-1:0]  r_db_cnt;
    logic             r_db_key;
    logic             r_press;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_enter_load;

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_period;
    logic             w_tick_due;

    logic             r_cnt_ld;
    logic             r_cnt_up;
    logic [9:0]       r_ld_data;

    always_ff @(posedge CLOCK_50) begin
        if (!KEY0) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= bus.key1_n;
            r_sync2 <= r_sync1;
        end
    end

    // r_press fires only on the 1->0 toggle of the debounced level; releases are dropped.
    always_ff @(posedge CLOCK_50) begin
        if (!KEY0) begin
            r_db_cnt <= '0;
            r_db_key <= 1'b1;
            r_press  <= 1'b0;
        end else begin
            r_press <= 1'b0;
            if (r_sync2 != r_db_key) begin
                if (r_db_cnt == DB_LAST) begin
                    r_db_key <= ~r_db_key;
                    r_db_cnt <= '0;
                    r_press  <= r_db_key;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = bus.run_sw ? RUN : PAUSE;
            RUN: begin
                if (r_press)          w_state_nxt = LOAD;
                else if (!bus.run_sw) w_state_nxt = PAUSE;
            end
            PAUSE: begin
                if (r_press)          w_state_nxt = LOAD;
                else if (bus.run_sw)  w_state_nxt = RUN;
            end
            LOAD:    w_state_nxt = bus.run_sw ? RUN : PAUSE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!KEY0) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    assign w_enter_load = (w_state_nxt == LOAD) && (r_state != LOAD);

    // Compare with >= so shortening the period mid-count ticks at once instead of wrapping.
    assign w_period   = DIV_BASE << bus.rate_sw;
    assign w_tick_due = (r_div >= (w_period - DIV_ONE));

    always_ff @(posedge CLOCK_50) begin
        if (!KEY0) begin
            r_div     <= '0;
            r_cnt_ld  <= 1'b0;
            r_cnt_up  <= 1'b1;
            r_ld_data <= '0;
        end else begin
            r_cnt_ld <= (w_state_nxt == LOAD);
            r_cnt_up <= bus.dir_sw;
            if (w_enter_load) begin
                r_ld_data <= bus.sw_val;
                r_div     <= '0;
            end else if (r_state == RUN) begin
                r_div <= w_tick_due ? '0 : (r_div + 1'b1);
            end
        end
    end

    // KEY0 gating keeps a pending tick from escaping in the cycle reset is applied.
    assign bus.cnt_en  = KEY0 && (r_state == RUN) && w_tick_due;
    assign bus.cnt_ld  = r_cnt_ld;
    assign bus.cnt_up  = r_cnt_up;
    assign bus.ld_data = r_ld_data;
    assign bus.state   = r_state;

endmodule

// File: tb/tb_led_count_ctrl.sv
// Bench for led_count_ctrl: directed steps followed by random operation, all
// outputs compared every cycle against a cycle-level behavioural model.
module tb_led_count_ctrl;

    localparam int CLK_DIV   = 4;
    localparam int DIV_W     = 32;
    localparam int DB_CYCLES = 3;
    localparam int DB_W      = 20;

    localparam int IDLE  = 0;
    localparam int RUN   = 1;
    localparam int PAUSE = 2;
    localparam int LOAD  = 3;

    logic CLOCK_50 = 1'b0;
    logic KEY0     = 1'b0;

    led_count_ctrl_if bus();

    led_count_ctrl #(
        .CLK_DIV  (CLK_DIV),
        .DIV_W    (DIV_W),
        .DB_CYCLES(DB_CYCLES),
        .DB_W     (DB_W)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .KEY0    (KEY0),
        .bus     (bus)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: mode, phase within tick period, key history and debounce streak.
    int         m_state;
    int         m_div;
    int         m_streak;
    bit         m_ld;
    bit         m_up;
    bit         m_lvl;
    bit         m_press;
    bit         m_h0;
    bit         m_h1;
    logic [9:0] m_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int period();
        return CLK_DIV << bus.rate_sw;
    endfunction

    task automatic model_reset();
        m_state  = IDLE;
        m_div    = 0;
        m_streak = 0;
        m_ld     = 1'b0;
        m_up     = 1'b1;
        m_lvl    = 1'b1;
        m_press  = 1'b0;
        m_h0     = 1'b1;
        m_h1     = 1'b1;
        m_data   = '0;
    endtask

    task automatic model_edge();
        int nst;
        int p;
        if (!KEY0) begin
            model_reset();
        end else begin
            p = period();
            if (m_state == RUN || m_state == PAUSE)
                nst = m_press ? LOAD : (bus.run_sw ? RUN : PAUSE);
            else
                nst = bus.run_sw ? RUN : PAUSE;
            if (nst == LOAD && m_state != LOAD) begin
                m_data = bus.sw_val;
                m_div  = 0;
            end else if (m_state == RUN) begin
                m_div = (m_div >= p - 1) ? 0 : m_div + 1;
            end
            m_ld = (nst == LOAD);
            m_up = bus.dir_sw;
            m_press = 1'b0;
            if (m_h1 != m_lvl) begin
                m_streak++;
                if (m_streak == DB_CYCLES) begin
                    m_lvl    = ~m_lvl;
                    m_streak = 0;
                    m_press  = (m_lvl == 1'b0);
                end
            end else begin
                m_streak = 0;
            end
            m_h1    = m_h0;
            m_h0    = bus.key1_n;
            m_state = nst;
        end
    endtask

    task automatic check_all();
        bit exp_en;
        exp_en = KEY0 && (m_state == RUN) && (m_div >= period() - 1);
        chk("state",   32'(bus.state),   32'(m_state));
        chk("cnt_ld",  32'(bus.cnt_ld),  32'(m_ld));
        chk("cnt_up",  32'(bus.cnt_up),  32'(m_up));
        chk("ld_data", 32'(bus.ld_data), 32'(m_data));
        chk("cnt_en",  32'(bus.cnt_en),  32'(exp_en));
        chk("en_ld_excl", 32'(bus.cnt_en & bus.cnt_ld), 32'(0));
    endtask

    task automatic cyc();
        @(posedge CLOCK_50);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        int k;
        int g;
        int ld_at;
        int en_at;
        int ld_cnt;
        int hold;

        bus.key1_n  = 1'b1;
        bus.run_sw  = 1'b1;
        bus.dir_sw  = 1'b1;
        bus.rate_sw = 2'd0;
        bus.sw_val  = 10'd0;
        model_reset();

        // Reset values
        repeat (3) cyc();
        chk("rst_state",   32'(bus.state),   32'(IDLE));
        chk("rst_ld_data", 32'(bus.ld_data), 32'(0));
        chk("rst_cnt_up",  32'(bus.cnt_up),  32'(1));

        // Run at P=4: first tick on the 4th RUN cycle
        KEY0 = 1'b1;
        cyc();
        chk("run_entry", 32'(bus.state), 32'(RUN));
        for (int i = 0; i < 12; i++) begin
            if (i > 0) cyc();
            chk("tick_p4", 32'(bus.cnt_en), 32'((i % 4) == 3));
        end

        // Pause with divider held at 2, resume
        cyc();
        cyc();
        bus.run_sw = 1'b0;
        cyc();
        chk("pause_entry", 32'(bus.state), 32'(PAUSE));
        for (int i = 0; i < 9; i++) begin
            cyc();
            chk("pause_no_en", 32'(bus.cnt_en), 32'(0));
        end
        bus.run_sw = 1'b1;
        cyc();
        chk("resume_c1", 32'(bus.cnt_en), 32'(0));
        cyc();
        chk("resume_c2", 32'(bus.cnt_en), 32'(1));

        // Debounced load
        bus.sw_val = 10'h2A5;
        bus.key1_n = 1'b0;
        ld_at  = -1;
        en_at  = -1;
        ld_cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            if (bus.cnt_ld) ld_cnt++;
            if (bus.cnt_ld && ld_at < 0) ld_at = i;
            if (ld_at > 0 && i > ld_at && bus.cnt_en && en_at < 0) en_at = i;
        end
        chk("ld_latency",  32'(ld_at),         32'(6));
        chk("ld_once",     32'(ld_cnt),        32'(1));
        chk("ld_value",    32'(bus.ld_data),   32'(10'h2A5));
        chk("ld_to_tick",  32'(en_at - ld_at), 32'(4));
        bus.key1_n = 1'b1;
        bus.sw_val = 10'h155;
        ld_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (bus.cnt_ld) ld_cnt++;
        end
        chk("release_no_ld", 32'(ld_cnt), 32'(0));

        // Two-cycle glitch must not load
        bus.key1_n = 1'b0;
        cyc();
        cyc();
        bus.key1_n = 1'b1;
        ld_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (bus.cnt_ld) ld_cnt++;
        end
        chk("glitch_no_ld", 32'(ld_cnt), 32'(0));
        chk("glitch_data",  32'(bus.ld_data), 32'(10'h2A5));

        // Rate 3 spacing, then drop to rate 0 with divider at 20
        bus.rate_sw = 2'd3;
        g = 0;
        do begin cyc(); g++; end while (!bus.cnt_en && g < 80);
        chk("wait_tick32", 32'(bus.cnt_en), 32'(1));
        k = 0;
        do begin cyc(); k++; end while (!bus.cnt_en && k < 80);
        chk("spacing32", 32'(k), 32'(32));
        g = 0;
        while (m_div != 20 && g < 64) begin cyc(); g++; end
        bus.rate_sw = 2'd0;
        #1;
        chk("rate_drop_tick", 32'(bus.cnt_en), 32'(1));
        k = 0;
        do begin cyc(); k++; end while (!bus.cnt_en && k < 20);
        chk("spacing4", 32'(k), 32'(4));

        // Press coinciding with run_sw falling
        bus.key1_n = 1'b0;
        g = 0;
        while (!m_press && g < 12) begin cyc(); g++; end
        chk("press_in_run", 32'(bus.state), 32'(RUN));
        bus.run_sw = 1'b0;
        cyc();
        chk("press_load",  32'(bus.state),  32'(LOAD));
        chk("press_ld",    32'(bus.cnt_ld), 32'(1));
        cyc();
        chk("press_pause", 32'(bus.state),  32'(PAUSE));
        bus.key1_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("after_press_no_en", 32'(bus.cnt_en), 32'(0));
        end

        // Reset during LOAD
        bus.run_sw = 1'b1;
        cyc();
        bus.key1_n = 1'b0;
        g = 0;
        while (m_state != LOAD && g < 12) begin cyc(); g++; end
        chk("reach_load", 32'(bus.state), 32'(LOAD));
        KEY0 = 1'b0;
        bus.key1_n = 1'b1;
        cyc();
        chk("rst_load_state", 32'(bus.state),   32'(IDLE));
        chk("rst_load_ld",    32'(bus.cnt_ld),  32'(0));
        chk("rst_load_data",  32'(bus.ld_data), 32'(0));
        chk("rst_load_up",    32'(bus.cnt_up),  32'(1));
        KEY0 = 1'b1;
        cyc();

        // Direction follows one cycle later
        bus.dir_sw = 1'b0;
        cyc();
        chk("dir_down", 32'(bus.cnt_up), 32'(0));
        bus.dir_sw = 1'b1;
        cyc();
        chk("dir_up", 32'(bus.cnt_up), 32'(1));

        // Random operation against the model
        hold = 0;
        for (int i = 0; i < 1500; i++) begin
            if (hold == 0) begin
                bus.key1_n = 1'($urandom_range(0, 1));
                hold = int'($urandom_range(1, 12));
            end
            hold--;
            if ($urandom_range(0, 15) == 0) bus.run_sw = ~bus.run_sw;
            bus.dir_sw = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 31) == 0)
                bus.rate_sw = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(2, 3))
                                                          : 2'($urandom_range(0, 1));
            bus.sw_val = 10'($urandom);
            KEY0 = ($urandom_range(0, 199) != 0);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/led_count_ctrl.md
Name: led_count_ctrl

Overview:
- Run/pause/load controller for the 10-bit LED counter datapath on the DE10-Lite board.
- Produces single-cycle enable and load strobes in the CLOCK_50 domain; replaces the derived slow clock with a clock-enable.
- Debounces the load pushbutton and supports a selectable count rate.
- The counter register itself sits outside this block and consumes cnt_en, cnt_ld, cnt_up and ld_data.

Parameters:
CLK_DIV, 5_000_000, base tick period in CLOCK_50 cycles (4 for simulation)
DIV_W, 32, divider counter width; must hold CLK_DIV*8
DB_CYCLES, 500_000, debounce stability window in cycles (3 for simulation)
DB_W, 20, debounce counter width

Ports:
CLOCK_50  in   1   system clock, 50 MHz
KEY0      in   1   synchronous active-low reset
key1_n    in   1   raw load pushbutton, active low, asynchronous to CLOCK_50
run_sw    in   1   1=run, 0=pause
dir_sw    in   1   1=count up, 0=count down
rate_sw   in   2   tick period = CLK_DIV << rate_sw
sw_val    in   10  load value
cnt_en    out  1   one-cycle count-enable strobe
cnt_ld    out  1   one-cycle load strobe
cnt_up    out  1   registered direction
ld_data   out  10  value captured for load
state     out  2   FSM state: IDLE=00, RUN=01, PAUSE=10, LOAD=11

Behaviour:
- Reset:
  - All logic is synchronous to the CLOCK_50 rising edge; KEY0=0 is sampled at that edge.
  - Reset values: state=IDLE, cnt_en=0, cnt_ld=0, cnt_up=1, ld_data=0, divider=0, debounce counter=0, sync flops=1, debounced key=1.
  - Reset asserted mid-operation aborts any LOAD or tick: outputs take reset values on the next edge, and no strobe is emitted in that cycle.
- Synchroniser: key1_n passes through 2 flops before any use.
- Debounce:
  - When the synchronised value differs from the debounced level, the counter increments; otherwise it clears.
  - When the counter reaches DB_CYCLES-1, the debounced level toggles and the counter clears.
  - A press event is a 1->0 transition of the debounced level, lasting one cycle. Release events are ignored.
- FSM:
  - IDLE: always exits after one cycle, to RUN if run_sw=1, else PAUSE.
  - RUN: press event -> LOAD. Else run_sw=0 -> PAUSE. Else stay.
  - PAUSE: press event -> LOAD. Else run_sw=1 -> RUN. Else stay.
  - LOAD: exactly one cycle, then -> RUN if run_sw=1, else PAUSE. A press event arriving in LOAD is not possible (debounce window > 1); no special handling is needed.
  - A press event has priority over a run_sw change in the same cycle.
- Load:
  - On entering LOAD, ld_data<=sw_val and the divider clears to 0.
  - cnt_ld is registered; it is high exactly in the cycle state==LOAD and low otherwise.
  - ld_data holds its value until the next load.
- Divider and tick:
  - The divider increments only while in RUN and holds its value in PAUSE (it does not clear).
  - Let P = CLK_DIV << rate_sw, computed at DIV_W bits.
  - When in RUN and divider >= P-1: the divider wraps to 0 and cnt_en=1 for one cycle.
  - The >= compare makes a rate decrease mid-period produce a tick on the next RUN cycle rather than a wrap-around.
  - cnt_en=0 in IDLE, PAUSE and LOAD. cnt_en and cnt_ld are never high together.
- Direction: cnt_up<=dir_sw every cycle, one cycle of latency.
- Latency:
  - Raw key low, held stable, to cnt_ld high = 2 sync cycles + DB_CYCLES cycles + 1 cycle for the state register.
  - With DB_CYCLES=3 the total is 6 cycles after the sampling edge.
- Steady-run tick spacing: exactly P cycles between cnt_en pulses.

Test Plan:
- Reset, run_sw=1, rate_sw=0, CLK_DIV=4 -> state IDLE then RUN; cnt_en pulses every 4 cycles, the first on the 4th RUN cycle; ld_data=0.
- run_sw 1->0 for 10 cycles after divider=2, then 0->1 -> no cnt_en while paused; the first pulse comes 2 RUN cycles after resume (divider held, not cleared).
- DB_CYCLES=3, sw_val=10'h2A5, key1_n low for 20 cycles -> state LOAD for one cycle; cnt_ld=1 for exactly one cycle, 6 cycles after the key edge; ld_data=10'h2A5; the next tick comes a full P cycles later. A 2-cycle glitch low produces no load.
- rate_sw 0->3 then back to 0 while divider=20 (P=32 -> 4) -> cnt_en on the next cycle, then every 4 cycles; at rate_sw=3 the pulse spacing is 32.
- Press event in the same cycle run_sw falls, while in RUN -> state goes to LOAD, then PAUSE. cnt_ld pulses once; cnt_en stays 0 afterward.
- KEY0 driven low during the LOAD cycle -> next edge state=IDLE, cnt_ld=0, ld_data=0, cnt_up=1. dir_sw toggle -> cnt_up follows one cycle later.
